// File: rtl/alex_pkg.sv
// Shared types and constants for the Alex relay SPI transmitter.
package alex_pkg;

  localparam int ALEX_WORD_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_TX,
    STROBE_TX,
    SHIFT_RX,
    STROBE_RX
  } alex_state_e;

endpackage

// File: rtl/alex_spi_word.sv
// Shifts one relay word MSB-first, then holds the selected load strobe for one bit period.
module alex_spi_word
  import alex_pkg::*;
#(
  parameter int CLK_DIV = 8,
  parameter int WORD_W  = ALEX_WORD_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              sel_rx,
  input  logic [WORD_W-1:0] word,
  output logic              spi_data,
  output logic              spi_clock,
  output logic              tx_strobe,
  output logic              rx_strobe,
  output logic              phase_end
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(WORD_W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_W - 1);
  localparam logic [BIT_W-1:0] STB_HALF2 = BIT_W'(1);

  logic              active_q, active_d;
  logic              strobe_ph_q, strobe_ph_d;
  logic              sel_q, sel_d;
  logic              sclk_q, sclk_d;
  logic              data_q, data_d;
  logic              tx_stb_q, tx_stb_d;
  logic              rx_stb_q, rx_stb_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              div_last;

  assign div_last = (div_q == DIV_LAST);

  // Last cycle of the shift phase or of the strobe phase; lets the caller chain the next frame gap-free.
  assign phase_end = active_q && div_last &&
                     (strobe_ph_q ? (bit_q == STB_HALF2) : (sclk_q && (bit_q == BIT_LAST)));

  always_comb begin
    active_d    = active_q;
    strobe_ph_d = strobe_ph_q;
    sel_d       = sel_q;
    sclk_d      = sclk_q;
    data_d      = data_q;
    tx_stb_d    = tx_stb_q;
    rx_stb_d    = rx_stb_q;
    shreg_d     = shreg_q;
    div_d       = div_q;
    bit_d       = bit_q;

    if (start) begin
      // shreg holds the bits still to be sent, already aligned to the MSB
      active_d    = 1'b1;
      strobe_ph_d = 1'b0;
      sel_d       = sel_rx;
      sclk_d      = 1'b0;
      data_d      = word[WORD_W-1];
      shreg_d     = {word[WORD_W-2:0], 1'b0};
      div_d       = '0;
      bit_d       = '0;
      tx_stb_d    = 1'b0;
      rx_stb_d    = 1'b0;
    end else if (active_q) begin
      div_d = div_last ? '0 : div_q + 1'b1;
      if (div_last) begin
        if (strobe_ph_q) begin
          if (bit_q == STB_HALF2) begin
            active_d    = 1'b0;
            strobe_ph_d = 1'b0;
            tx_stb_d    = 1'b0;
            rx_stb_d    = 1'b0;
            bit_d       = '0;
          end else begin
            bit_d = STB_HALF2;
          end
        end else if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d = 1'b0;
          if (bit_q == BIT_LAST) begin
            strobe_ph_d = 1'b1;
            data_d      = 1'b0;
            bit_d       = '0;
            tx_stb_d    = !sel_q;
            rx_stb_d    = sel_q;
          end else begin
            bit_d   = bit_q + 1'b1;
            data_d  = shreg_q[WORD_W-1];
            shreg_d = shreg_q << 1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      active_q    <= 1'b0;
      strobe_ph_q <= 1'b0;
      sel_q       <= 1'b0;
      sclk_q      <= 1'b0;
      data_q      <= 1'b0;
      tx_stb_q    <= 1'b0;
      rx_stb_q    <= 1'b0;
      shreg_q     <= '0;
      div_q       <= '0;
      bit_q       <= '0;
    end else begin
      active_q    <= active_d;
      strobe_ph_q <= strobe_ph_d;
      sel_q       <= sel_d;
      sclk_q      <= sclk_d;
      data_q      <= data_d;
      tx_stb_q    <= tx_stb_d;
      rx_stb_q    <= rx_stb_d;
      shreg_q     <= shreg_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
    end
  end

  assign spi_data  = data_q;
  assign spi_clock = sclk_q;
  assign tx_strobe = tx_stb_q;
  assign rx_strobe = rx_stb_q;

endmodule

// File: rtl/alex_spi_tx.sv
// Alex relay transmitter: change detect, force latch and TX/RX frame sequencing around one word shifter.
module alex_spi_tx
  import alex_pkg::*;
#(
  parameter int CLK_DIV = 8,
  parameter int WORD_W  = ALEX_WORD_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] tx_word,
  input  logic [WORD_W-1:0] rx_word,
  input  logic              force_req,
  output logic              SPI_data,
  output logic              SPI_clock,
  output logic              Tx_load_strobe,
  output logic              Rx_load_strobe,
  output logic              busy
);

  alex_state_e       state_q, state_d;
  logic              first_q, first_d;
  logic              force_q, force_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic [WORD_W-1:0] tx_sent_q, tx_sent_d;
  logic [WORD_W-1:0] rx_sent_q, rx_sent_d;

  logic              pending;
  logic              word_start;
  logic              word_sel_rx;
  logic [WORD_W-1:0] word_mux;
  logic              phase_end;

  assign pending = force_q || first_q || (tx_word != tx_sent_q) || (rx_word != rx_sent_q);

  always_comb begin
    state_d   = state_q;
    first_d   = first_q;
    force_d   = force_q || force_req;
    start_d   = 1'b0;
    busy_d    = busy_q;
    tx_sent_d = tx_sent_q;
    rx_sent_d = rx_sent_q;

    unique case (state_q)
      IDLE: begin
        if (pending) begin
          tx_sent_d = tx_word;
          rx_sent_d = rx_word;
          force_d   = 1'b0;
          first_d   = 1'b0;
          start_d   = 1'b1;
          state_d   = SHIFT_TX;
        end
      end
      SHIFT_TX: begin
        if (start_q) busy_d = 1'b1;
        if (phase_end) state_d = STROBE_TX;
      end
      STROBE_TX: begin
        if (phase_end) state_d = SHIFT_RX;
      end
      SHIFT_RX: begin
        if (phase_end) state_d = STROBE_RX;
      end
      STROBE_RX: begin
        if (phase_end) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The RX frame is launched on the last TX strobe cycle so the two frames abut.
  assign word_start  = start_q || ((state_q == STROBE_TX) && phase_end);
  assign word_sel_rx = (state_q == STROBE_TX);
  assign word_mux    = start_q ? tx_sent_q : rx_sent_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      first_q   <= 1'b1;
      force_q   <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      tx_sent_q <= '0;
      rx_sent_q <= '0;
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      force_q   <= force_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      tx_sent_q <= tx_sent_d;
      rx_sent_q <= rx_sent_d;
    end
  end

  alex_spi_word #(
    .CLK_DIV (CLK_DIV),
    .WORD_W  (WORD_W)
  ) u_word (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (word_start),
    .sel_rx    (word_sel_rx),
    .word      (word_mux),
    .spi_data  (SPI_data),
    .spi_clock (SPI_clock),
    .tx_strobe (Tx_load_strobe),
    .rx_strobe (Rx_load_strobe),
    .phase_end (phase_end)
  );

  assign busy = busy_q;

endmodule

// File: doc/alex_spi_tx.md
# alex_spi_tx

Serial transmitter that drives the Alex filter/antenna board's relay shift registers. It accepts the parallel TX and RX relay words assembled upstream (antenna select, Rx_1_out, filter bits) and shifts them out MSB-first over a three-wire SPI link with separate load strobes. It sends automatically when either word changes and on explicit request, so the Alex relays always mirror the current control state. It sits between the command/control decode and the Alex header pins.

## Interface
Parameters:
- CLK_DIV, 8, SPI clock half-period in `clock` cycles; legal range 1..255.
- WORD_W, 16, bits per relay word.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- tx_word  in  WORD_W  TX relay word, sampled only at transfer start.
- rx_word  in  WORD_W  RX relay word, sampled only at transfer start.
- force  in  1  single-cycle request to resend current words even if unchanged.
- SPI_data  out  1  serial data, MSB first.
- SPI_clock  out  1  serial clock; Alex samples SPI_data on its rising edge.
- Tx_load_strobe  out  1  latch pulse for the TX register.
- Rx_load_strobe  out  1  latch pulse for the RX register.
- busy  out  1  high for the whole transfer.

## Operation
- All outputs registered. Reset values: SPI_data 0, SPI_clock 0, Tx_load_strobe 0, Rx_load_strobe 0, busy 0; pending flag set to 1, so one transfer always follows reset.
- States: IDLE -> SHIFT_TX -> STROBE_TX -> SHIFT_RX -> STROBE_RX -> IDLE.
- IDLE: pending = force_latched OR first-after-reset OR (tx_word != tx_sent) OR (rx_word != rx_sent). If pending: snapshot tx_word/rx_word into tx_sent/rx_sent, clear force latch, go SHIFT_TX.
- SHIFT_x: WORD_W bits, index WORD_W-1 down to 0. Per bit: SPI_data = bit, SPI_clock low for CLK_DIV cycles, then high for CLK_DIV cycles. SPI_data changes only when SPI_clock goes low.
- STROBE_x: SPI_clock low, SPI_data 0, corresponding strobe high for 2*CLK_DIV cycles.
- Input changes during a transfer do not alter the bits being sent. The IDLE compare after completion triggers a new transfer with the new values.
- force asserted in any state is latched. It causes exactly one extra transfer, and multiple force pulses during one transfer collapse to one.
- Only one strobe is high at a time, and never while SPI_clock is high.

## Timing
- Start latency: the pending condition is evaluated in IDLE at edge N. At edge N+1 (outputs after N+1) busy = 1, SPI_clock = 0, SPI_data = tx_word[WORD_W-1].
- Bit period 2*CLK_DIV cycles. Word frame (WORD_W+1)*2*CLK_DIV cycles. Full transfer 2*(WORD_W+1)*2*CLK_DIV cycles, which is 544 for defaults.
- busy falls on the same edge that Rx_load_strobe falls. At least one IDLE cycle separates back-to-back transfers.
- Reset mid-transfer: at the first edge with reset_n low, all outputs return to reset values and no strobe is issued. After release, a full transfer of the current words starts one edge later.
- After reset release with no change and no force pending, the block performs the reset-triggered transfer only, then stays idle with SPI_clock static low.

## Structure
- alex_pkg holds the state enum (IDLE, SHIFT_TX, STROBE_TX, SHIFT_RX, STROBE_RX) and the default WORD_W = 16 constant.
- Sub-module alex_spi_word: shifts one WORD_W word plus strobe phase with start/done handshake. It is instantiated once, with word select and strobe steering done in the top FSM. The top contains the change detect, force latch and sequencing.
- Counters: a half-period divider of width $clog2(CLK_DIV+1) and a bit counter of width $clog2(WORD_W+1).

## Test plan
- CLK_DIV=2, tx_word=16'hA5C3, rx_word=16'h0102, release reset: capturing SPI_data on SPI_clock rising edges gives A5C3, then a Tx_load_strobe of 4 cycles, then 0102, then a 4-cycle Rx_load_strobe. busy is high for exactly 136 cycles.
- After the first transfer, hold words constant and force=0 for 2000 cycles: no SPI_clock edges, busy stays 0.
- Change rx_word to 16'h0304 during bit 5 of SHIFT_TX: the current transfer still sends A5C3/0102, then after one IDLE cycle a second transfer sends A5C3/0304.
- In idle, pulse force for 1 cycle with unchanged words: exactly one transfer of identical data. Three force pulses during one transfer cause exactly one extra transfer.
- Assert reset_n=0 during SHIFT_RX bit 7: on the next edge all outputs are 0 and no Rx_load_strobe appears. After release, a complete transfer occurs.
- CLK_DIV=1, WORD_W=16: bit period is 2 cycles, total transfer is 68 cycles, and the first-bit latency of one edge after pending is detected holds.
